// File: rtl/ctrl_reg_bank.sv
// ctrl_reg_bank: register-bus slave with version, sticky status, a 64-bit
// timestamp counter with coherent capture, scratch, pulse and control words.
// Reads return one cycle after the address is presented.
module ctrl_reg_bank #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          NUM_CTRL  = 4,
  parameter logic [31:0] VERSION   = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [15:0]              reg_addr,
  input  logic [31:0]              reg_wdata,
  input  logic                     reg_wr,
  output logic [31:0]              reg_rdata,
  output logic                     reg_hit,
  input  logic [7:0]               status_set,
  output logic [32*NUM_CTRL-1:0]   ctrl_out,
  output logic [31:0]              pulse_out
);

  localparam logic [3:0] OFF_VERSION = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h1;
  localparam logic [3:0] OFF_TS_CAP  = 4'h2;
  localparam logic [3:0] OFF_TS_LO   = 4'h3;
  localparam logic [3:0] OFF_TS_HI   = 4'h4;
  localparam logic [3:0] OFF_SCRATCH = 4'h5;
  localparam logic [3:0] OFF_PULSE   = 4'h6;
  localparam int         CTRL_BASE   = 8;

  logic [3:0]  offset;
  logic        win_hit;
  logic        wr_en;

  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
  logic [31:0] status_q, status_d;
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] pulse_q, pulse_d;
  logic [31:0] ctrl_q [NUM_CTRL];
  logic [31:0] ctrl_d [NUM_CTRL];

  logic        cnt_en;
  logic        cnt_clr;
  logic        cnt_wrap;
  logic        status_w1c;

  assign offset  = reg_addr[3:0];
  assign win_hit = (reg_addr[15:4] == BASE_ADDR[15:4]);
  assign wr_en   = reg_wr && win_hit;

  // Counter control: clear comes from a write of CTRL[0] bit 1 and beats increment.
  always_comb begin
    cnt_en   = ctrl_q[0][0];
    cnt_clr  = wr_en && (offset == 4'(CTRL_BASE)) && reg_wdata[1];
    cnt_wrap = cnt_en && !cnt_clr && (&cnt_q);
    cnt_d    = cnt_clr ? 64'd0 : (cnt_en ? cnt_q + 64'd1 : cnt_q);
  end

  // Register write decode; set sources win over a same-cycle W1C.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    status_w1c = wr_en && (offset == OFF_STATUS);
    status_d   = 32'd0;
    status_d[7:0] = (status_q[7:0] & ~(status_w1c ? reg_wdata[7:0] : 8'h00)) | status_set;
    status_d[31]  = (status_q[31] & ~(status_w1c && reg_wdata[31])) | cnt_wrap;

    shadow_d  = (wr_en && offset == OFF_TS_CAP) ? cnt_q : shadow_q;
    scratch_d = (wr_en && offset == OFF_SCRATCH) ? reg_wdata : scratch_q;
    pulse_d   = (wr_en && offset == OFF_PULSE) ? reg_wdata : 32'd0;

    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (wr_en && offset == 4'(CTRL_BASE + i)) ctrl_d[i] = reg_wdata;
    end
    // The clear bit is an action, not state.
    ctrl_d[0][1] = 1'b0;
  end

  // Read mux: pure function of the address and current state, independent of reg_wr.
  always_comb begin
    rdata_d = 32'd0;
    hit_d   = 1'b0;
    if (win_hit) begin
      case (offset)
        OFF_VERSION: begin rdata_d = VERSION;         hit_d = 1'b1; end
        OFF_STATUS:  begin rdata_d = status_q;        hit_d = 1'b1; end
        OFF_TS_CAP:  begin rdata_d = 32'd0;           hit_d = 1'b1; end
        OFF_TS_LO:   begin rdata_d = shadow_q[31:0];  hit_d = 1'b1; end
        OFF_TS_HI:   begin rdata_d = shadow_q[63:32]; hit_d = 1'b1; end
        OFF_SCRATCH: begin rdata_d = scratch_q;       hit_d = 1'b1; end
        default: begin
          for (int i = 0; i < NUM_CTRL; i++) begin
            if (offset == 4'(CTRL_BASE + i)) begin
              rdata_d = ctrl_q[i];
              hit_d   = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State registers; everything, including the control array, clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q   <= 32'd0;
      hit_q     <= 1'b0;
      status_q  <= 32'd0;
      cnt_q     <= 64'd0;
      shadow_q  <= 64'd0;
      scratch_q <= 32'd0;
      pulse_q   <= 32'd0;
      // NOTE: the control array is small and drives outputs, so it is reset like any flop.
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

  // Flatten control words onto the output bus.
  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_CTRL; i++) ctrl_out[32*i +: 32] = ctrl_q[i];
  end

  assign reg_rdata = rdata_q;
  assign reg_hit   = hit_q;
  assign pulse_out = pulse_q;

  // A write with an unknown address means the master is broken.
  a_wr_addr_known: assert property (@(posedge clk) disable iff (!reset_n)
    reg_wr |-> !$isunknown(reg_addr));

endmodule
